cordic_uart_sequencer: RTL and testbench

- Frame sequencer between the UART receiver, the CORDIC pipeline and the UART transmitter.
- Assembles received bytes into one angle word and issues it to the CORDIC as a single-cycle request.
- Captures the cos/sin result and serialises it back to the transmitter byte by byte over a valid/ready handshake.
- Handles inter-byte timeouts, receive errors and a missing CORDIC result.

---
 rtl/cordic_uart_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_cordic_uart_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_uart_sequencer.sv
// Frame sequencer: UART bytes -> CORDIC angle word, CORDIC cos/sin result -> UART bytes.
// Define SEQ_CHECKSUM_EN to add an XOR checksum byte to both the RX and TX frames.
module cordic_uart_sequencer #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BYTE_TIMEOUT   = 1024,
    parameter int unsigned RESULT_TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              rx_err_i,
    output logic [DATA_W-1:0] cordic_angle_o,
    output logic              cordic_valid_o,
    input  logic [DATA_W-1:0] cordic_cos_i,
    input  logic [DATA_W-1:0] cordic_sin_i,
    input  logic              cordic_valid_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              frame_err_o,
    output logic              drop_o
);

    localparam int unsigned NB = DATA_W / 8;
`ifdef SEQ_CHECKSUM_EN
    localparam int unsigned RX_BYTES = NB + 1;
    localparam int unsigned TX_BYTES = 2 * NB + 1;
`else
    localparam int unsigned RX_BYTES = NB;
    localparam int unsigned TX_BYTES = 2 * NB;
`endif
    localparam int unsigned IDX_W = $clog2(TX_BYTES + 1);
    localparam int unsigned T_MAX = (BYTE_TIMEOUT > RESULT_TIMEOUT) ? BYTE_TIMEOUT
                                                                     : RESULT_TIMEOUT;
    localparam int unsigned TMR_W = $clog2(T_MAX) + 1;

    localparam logic [IDX_W-1:0] RX_LAST  = IDX_W'(RX_BYTES - 1);
    localparam logic [IDX_W-1:0] TX_LAST  = IDX_W'(TX_BYTES - 1);
    localparam logic [TMR_W-1:0] BYTE_LIM = TMR_W'(BYTE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RES_LIM  = TMR_W'(RESULT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRxCollect,
        StIssue,
        StWaitRes,
        StTxSend
    } state_e;

    state_e              state;
    logic [IDX_W-1:0]    index;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_inc;
    logic [DATA_W-1:0]   angle_buf;
    logic [DATA_W-1:0]   angle_ins;
    logic [2*DATA_W-1:0] res_sr;
    logic                rx_good;
    logic                rx_bad;
`ifdef SEQ_CHECKSUM_EN
    localparam logic [IDX_W-1:0] TX_CSUM = IDX_W'(TX_BYTES - 2);
    logic [7:0]          rx_csum;
    logic [7:0]          tx_csum;
`endif

    assign rx_good   = rx_valid_i & ~rx_err_i;
    assign rx_bad    = rx_valid_i & rx_err_i;
    assign timer_inc = (&timer) ? timer : timer + 1'b1;
    assign busy_o    = (state != StIdle);

    // Assembled word with the incoming byte placed at the current index (LSB first).
    always_comb begin
        angle_ins = angle_buf;
        for (int b = 0; b < int'(NB); b++) begin
            if (index == IDX_W'(b)) begin
                angle_ins[8*b +: 8] = rx_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= StIdle;
            index          <= '0;
            timer          <= '0;
            angle_buf      <= '0;
            res_sr         <= '0;
            cordic_angle_o <= '0;
            cordic_valid_o <= 1'b0;
            tx_data_o      <= '0;
            tx_valid_o     <= 1'b0;
            frame_err_o    <= 1'b0;
            drop_o         <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            rx_csum        <= '0;
            tx_csum        <= '0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            drop_o      <= 1'b0;
            case (state)
                StIdle: begin
                    timer <= '0;
                    if (rx_good) begin
                        angle_buf <= angle_ins;
                        index     <= IDX_W'(1);
`ifdef SEQ_CHECKSUM_EN
                        rx_csum   <= rx_data_i;
`endif
                        if (RX_BYTES == 1) begin
                            cordic_angle_o <= angle_ins;
                            cordic_valid_o <= 1'b1;
                            state          <= StIssue;
                        end else begin
                            state <= StRxCollect;
                        end
                    end else if (rx_bad) begin
                        frame_err_o <= 1'b1;
                    end
                end

                StRxCollect: begin
                    if (rx_bad) begin
                        frame_err_o <= 1'b1;
                        angle_buf   <= '0;
                        index       <= '0;
                        timer       <= '0;
                        state       <= StIdle;
                    end else if (rx_good) begin
                        // A byte always restarts the timer, even on the expiry cycle.
                        timer <= '0;
`ifdef SEQ_CHECKSUM_EN
                        if (index == RX_LAST) begin
                            index <= '0;
                            if (rx_data_i == rx_csum) begin
                                cordic_angle_o <= angle_buf;
                                cordic_valid_o <= 1'b1;
                                state          <= StIssue;
                            end else begin
                                frame_err_o <= 1'b1;
                                angle_buf   <= '0;
                                state       <= StIdle;
                            end
                        end else begin
                            angle_buf <= angle_ins;
                            rx_csum   <= rx_csum ^ rx_data_i;
                            index     <= index + 1'b1;
                        end
`else
                        angle_buf <= angle_ins;
                        index     <= index + 1'b1;
                        if (index == RX_LAST) begin
                            cordic_angle_o <= angle_ins;
                            cordic_valid_o <= 1'b1;
                            state          <= StIssue;
                        end
`endif
                    end else if (timer == BYTE_LIM) begin
                        frame_err_o <= 1'b1;
                        angle_buf   <= '0;
                        index       <= '0;
                        timer       <= '0;
                        state       <= StIdle;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                StIssue: begin
                    drop_o         <= rx_valid_i;
                    cordic_valid_o <= 1'b0;
                    index          <= '0;
                    timer          <= '0;
                    state          <= StWaitRes;
                end

                StWaitRes: begin
                    drop_o <= rx_valid_i;
                    if (cordic_valid_i) begin
                        res_sr     <= {cordic_sin_i, cordic_cos_i};
                        tx_data_o  <= cordic_cos_i[7:0];
                        tx_valid_o <= 1'b1;
                        index      <= '0;
                        timer      <= '0;
`ifdef SEQ_CHECKSUM_EN
                        tx_csum    <= '0;
`endif
                        state      <= StTxSend;
                    end else if (timer == RES_LIM) begin
                        frame_err_o <= 1'b1;
                        timer       <= '0;
                        state       <= StIdle;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                StTxSend: begin
                    drop_o <= rx_valid_i;
                    if (tx_valid_o && tx_ready_i) begin
                        if (index == TX_LAST) begin
                            tx_valid_o <= 1'b0;
                            index      <= '0;
                            state      <= StIdle;
                        end else begin
                            index  <= index + 1'b1;
                            res_sr <= res_sr >> 8;
`ifdef SEQ_CHECKSUM_EN
                            tx_csum <= tx_csum ^ tx_data_o;
                            if (index == TX_CSUM) begin
                                tx_data_o <= tx_csum ^ tx_data_o;
                            end else begin
                                tx_data_o <= res_sr[15:8];
                            end
`else
                            tx_data_o <= res_sr[15:8];
`endif
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_uart_sequencer.sv
// Directed self-checking bench for cordic_uart_sequencer (DATA_W=16); follows SEQ_CHECKSUM_EN.
module tb_cordic_uart_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [15:0] cordic_angle;
    logic        cordic_valid;
    logic [15:0] cordic_cos = '0;
    logic [15:0] cordic_sin = '0;
    logic        cordic_res_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        frame_err;
    logic        drop;

    int n_checks = 0;
    int n_errors = 0;

    cordic_uart_sequencer #(
        .DATA_W         (16),
        .BYTE_TIMEOUT   (1024),
        .RESULT_TIMEOUT (256)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rx_err_i       (rx_err),
        .cordic_angle_o (cordic_angle),
        .cordic_valid_o (cordic_valid),
        .cordic_cos_i   (cordic_cos),
        .cordic_sin_i   (cordic_sin),
        .cordic_valid_i (cordic_res_valid),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .busy_o         (busy),
        .frame_err_o    (frame_err),
        .drop_o         (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: event counts, accepted TX bytes, stall stability.
    logic [7:0] tx_q[$];
    int         cnt_issue = 0;
    int         cnt_ferr = 0;
    int         cnt_drop = 0;
    int         cnt_txv = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (cordic_valid) cnt_issue <= cnt_issue + 1;
        if (frame_err) cnt_ferr <= cnt_ferr + 1;
        if (drop) cnt_drop <= cnt_drop + 1;
        if (tx_valid) cnt_txv <= cnt_txv + 1;
        if (prev_stall && tx_valid) check("stall_hold", 32'(tx_data), 32'(prev_data));
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic err);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        tick(1);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi);
        rx_byte(lo, 1'b0);
        rx_byte(hi, 1'b0);
`ifdef SEQ_CHECKSUM_EN
        rx_byte(lo ^ hi, 1'b0);
`endif
    endtask

    task automatic send_result(input logic [15:0] cos_v, input logic [15:0] sin_v);
        cordic_cos       = cos_v;
        cordic_sin       = sin_v;
        cordic_res_valid = 1'b1;
        tick(1);
        cordic_res_valid = 1'b0;
    endtask

    // Bounded drain: tx_ready follows a repeating 4-cycle pattern (bit i = cycle i).
    task automatic drain(input logic [3:0] pat);
        int i;
        i = 0;
        while (busy && i < 40) begin
            tx_ready = pat[i % 4];
            tick(1);
            i++;
        end
        tx_ready = 1'b0;
        if (busy) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_tx(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_q[$];
        exp_q = '{e0, e1, e2, e3};
`ifdef SEQ_CHECKSUM_EN
        exp_q.push_back(e0 ^ e1 ^ e2 ^ e3);
`endif
        check("tx_count", 32'(tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < tx_q.size()) check("tx_byte", 32'(tx_q[i]), 32'(exp_q[i]));
        end
        tx_q.delete();
    endtask

    int ferr0;
    int iss0;
    int txv0;
    int drop0;

    initial begin
        tick(3);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_cordic_valid", 32'(cordic_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({frame_err, drop}), 32'd0);
        check("rst_angle", 32'(cordic_angle), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        tick(2);

        // Basic frame, tx_ready held high.
        tx_ready = 1'b1;
        send_frame(8'h34, 8'h12);
        check("issue_valid", 32'(cordic_valid), 32'd1);
        check("issue_angle", 32'(cordic_angle), 32'h1234);
        tick(1);
        check("issue_pulse", 32'(cordic_valid), 32'd0);
        check("issue_hold", 32'(cordic_angle), 32'h1234);
        send_result(16'hABCD, 16'h0102);
        check("tx_first_valid", 32'(tx_valid), 32'd1);
        check("tx_first_data", 32'(tx_data), 32'hCD);
        drain(4'b1111);
        expect_tx(8'hCD, 8'hAB, 8'h02, 8'h01);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_tx_valid", 32'(tx_valid), 32'd0);
        check("t1_issues", 32'(cnt_issue), 32'd1);

        // Drop in WAIT_RES, then a stalled transmit with ready 1,0,0,1.
        send_frame(8'h78, 8'h56);
        check("t2_angle", 32'(cordic_angle), 32'h5678);
        tick(1);
        drop0 = cnt_drop;
        rx_byte(8'h99, 1'b0);
        check("t2_drop", 32'(drop), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        tick(1);
        check("t2_drop_pulse", 32'(drop), 32'd0);
        send_result(16'h1122, 16'h3344);
        drain(4'b1001);
        expect_tx(8'h22, 8'h11, 8'h44, 8'h33);
        check("t2_issues", 32'(cnt_issue), 32'd2);
        check("t2_drop_count", 32'(cnt_drop - drop0), 32'd1);

        // Inter-byte timeout.
        ferr0 = cnt_ferr;
        iss0  = cnt_issue;
        rx_byte(8'h34, 1'b0);
        tick(1000);
        check("t3_no_err_early", 32'(cnt_ferr - ferr0), 32'd0);
        check("t3_busy_early", 32'(busy), 32'd1);
        tick(40);
        check("t3_ferr", 32'(cnt_ferr - ferr0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_no_issue", 32'(cnt_issue - iss0), 32'd0);

        // Byte on the expiry cycle wins.
        rx_byte(8'h00, 1'b0);
        tick(1023);
        rx_byte(8'h40, 1'b0);
`ifdef SEQ_CHECKSUM_EN
        rx_byte(8'h40, 1'b0);
`endif
        check("t3b_issue", 32'(cordic_valid), 32'd1);
        check("t3b_angle", 32'(cordic_angle), 32'h4000);
        check("t3b_no_err", 32'(cnt_ferr - ferr0), 32'd1);

        // Result timeout.
        tick(1);
        ferr0 = cnt_ferr;
        txv0  = cnt_txv;
        tick(240);
        check("t5_no_err_early", 32'(cnt_ferr - ferr0), 32'd0);
        check("t5_busy_early", 32'(busy), 32'd1);
        tick(30);
        check("t5_ferr", 32'(cnt_ferr - ferr0), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_no_tx", 32'(cnt_txv - txv0), 32'd0);

        // Receive errors in RX_COLLECT and IDLE.
        iss0 = cnt_issue;
        rx_byte(8'h34, 1'b0);
        rx_byte(8'h12, 1'b1);
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        tick(1);
        check("t4_ferr_pulse", 32'(frame_err), 32'd0);
        rx_byte(8'h55, 1'b1);
        check("t4_idle_ferr", 32'(frame_err), 32'd1);
        check("t4_idle_stay", 32'(busy), 32'd0);
        check("t4_no_issue", 32'(cnt_issue - iss0), 32'd0);
        tick(1);

`ifdef SEQ_CHECKSUM_EN
        rx_byte(8'h34, 1'b0);
        rx_byte(8'h12, 1'b0);
        rx_byte(8'h00, 1'b0);
        check("t6_ferr", 32'(frame_err), 32'd1);
        check("t6_no_issue", 32'(cordic_valid), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        tick(1);
`endif

        // Asynchronous reset while a byte is pending.
        send_frame(8'h11, 8'h11);
        tick(1);
        send_result(16'h0A0B, 16'h0C0D);
        check("t7_pending", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_tx_valid", 32'(tx_valid), 32'd0);
        check("t7_async_busy", 32'(busy), 32'd0);
        check("t7_async_angle", 32'(cordic_angle), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        tx_q.delete();
        send_frame(8'h00, 8'h40);
        check("t7_recover_angle", 32'(cordic_angle), 32'h4000);
        check("t7_recover_issue", 32'(cordic_valid), 32'd1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
